tag_io_unit: RTL and testbench

// - Downstream consumer of the 128-bit tag register output in the ASCON-128 datapath.
// - Encrypt mode: serialises the captured tag onto a 32-bit valid/ready output stream, MSB word first.
// - Decrypt mode: accepts the received (expected) tag as four 32-bit words.

---
 rtl/ascon_pack.sv | 24 ++
 rtl/tag_io_unit_if.sv | 29 ++
 rtl/tag_io_unit.sv | 110 +++++++++++
 tb/tb_tag_io_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON datapath definitions: tag I/O FSM states, word geometry and mode encoding.
package ascon_pack;

  localparam int WORD_W    = 32;
  localparam int TAG_W     = 128;
  localparam int TAG_WORDS = TAG_W / WORD_W;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    TIO_IDLE,
    TIO_EMIT,
    TIO_CHECK,
    TIO_DONE
  } tag_io_state_t;

  // Word idx of a tag, counted from the most significant end.
  function automatic logic [WORD_W-1:0] tag_word(input logic [TAG_W-1:0] tag,
                                                 input logic [1:0]       idx);
    return tag[TAG_W-1 - WORD_W*int'(idx) -: WORD_W];
  endfunction

endpackage

// File: rtl/tag_io_unit_if.sv
// Control, tag-out stream and expected-tag-in stream of the tag I/O unit.
interface tag_io_unit_if;
  import ascon_pack::*;

  logic              start_i;
  logic              mode_i;
  logic [TAG_W-1:0]  tag_i;
  logic [WORD_W-1:0] tag_word_o;
  logic              tag_valid_o;
  logic              tag_ready_i;
  logic [WORD_W-1:0] exp_word_i;
  logic              exp_valid_i;
  logic              exp_ready_o;
  logic              busy_o;
  logic              done_o;
  logic              auth_ok_o;

  // Driven by the surrounding datapath.
  modport master (
    output start_i, mode_i, tag_i, tag_ready_i, exp_word_i, exp_valid_i,
    input  tag_word_o, tag_valid_o, exp_ready_o, busy_o, done_o, auth_ok_o
  );

  // The tag I/O unit itself.
  modport slave (
    input  start_i, mode_i, tag_i, tag_ready_i, exp_word_i, exp_valid_i,
    output tag_word_o, tag_valid_o, exp_ready_o, busy_o, done_o, auth_ok_o
  );
endinterface

// File: rtl/tag_io_unit.sv
// Tag I/O unit: emits the captured tag as 32-bit words (encrypt) or checks a
// received tag against it in constant time (decrypt).
module tag_io_unit
  import ascon_pack::*;
(
  input  logic          clk,
  input  logic          reset,
  tag_io_unit_if.slave  io
);

  tag_io_state_t     state;
  logic              mode_q;
  logic [TAG_W-1:0]  tag_q;
  logic [1:0]        cnt;
  logic [WORD_W-1:0] diff;

  logic              tag_valid;
  logic              exp_ready;
  logic              busy;
  logic              done;
  logic              auth_ok;

  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] diff_next;
  logic              last_word;

  assign cur_word  = tag_word(tag_q, cnt);
  assign diff_next = diff | (io.exp_word_i ^ cur_word);
  assign last_word = (cnt == 2'(TAG_WORDS - 1));

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later lines see same-cycle updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TIO_IDLE;
      mode_q    <= MODE_ENC;
      tag_q     <= '0;
      cnt       <= '0;
      diff      <= '0;
      tag_valid <= 1'b0;
      exp_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      auth_ok   <= 1'b0;
    end else begin
      case (state)
        TIO_IDLE: begin
          if (io.start_i) begin
            tag_q   <= io.tag_i;
            mode_q  <= io.mode_i;
            cnt     <= '0;
            diff    <= '0;
            auth_ok <= 1'b0;
            busy    <= 1'b1;
            if (io.mode_i == MODE_DEC) begin
              state     <= TIO_CHECK;
              exp_ready <= 1'b1;
            end else begin
              state     <= TIO_EMIT;
              tag_valid <= 1'b1;
            end
          end
        end

        TIO_EMIT: begin
          if (io.tag_ready_i) begin
            if (last_word) begin
              state     <= TIO_DONE;
              tag_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end

        // Every word is folded into diff; a mismatch never shortens the check.
        TIO_CHECK: begin
          if (io.exp_valid_i) begin
            diff <= diff_next;
            if (last_word) begin
              state     <= TIO_DONE;
              exp_ready <= 1'b0;
              done      <= 1'b1;
              auth_ok   <= (mode_q == MODE_DEC) && (diff_next == '0);
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end

        TIO_DONE: begin
          state <= TIO_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= TIO_IDLE;
      endcase
    end
  end

  assign io.tag_word_o  = cur_word;
  assign io.tag_valid_o = tag_valid;
  assign io.exp_ready_o = exp_ready;
  assign io.busy_o      = busy;
  assign io.done_o      = done;
  assign io.auth_ok_o   = auth_ok;

endmodule

// File: tb/tb_tag_io_unit.sv
// Scoreboard bench for tag_io_unit: encrypt streaming, decrypt verdicts, stalls and reset abort.
module tb_tag_io_unit;
  import ascon_pack::*;

  localparam logic [127:0] T       = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] T_LAST  = T ^ 128'h1;
  localparam logic [127:0] T_FIRST = T ^ (128'h1 << 96);

  logic clk = 1'b0;
  logic reset;
  tag_io_unit_if io ();

  tag_io_unit dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] sb_words[$];
  logic        sb_auth[$];

  // Reference word extraction by shifting, MSB word first.
  function automatic logic [31:0] ref_word(input logic [127:0] t, input int i);
    logic [127:0] s;
    s = t >> (32 * (3 - i));
    return s[31:0];
  endfunction

  task automatic recover(input string name);
    $display("FAIL %s: no done_o within cycle budget (got none, required one)", name);
    miscompares++;
    vectors++;
    sb_words.delete();
    sb_auth.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({io.tag_valid_o, io.exp_ready_o, io.busy_o, io.done_o, io.auth_ok_o} !== 5'b0 ||
        io.tag_word_o !== 32'h0) begin
      $display("FAIL %s: outputs v/r/b/d/a=%b word=%h, required 00000 word=00000000", name,
               {io.tag_valid_o, io.exp_ready_o, io.busy_o, io.done_o, io.auth_ok_o},
               io.tag_word_o);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io.start_i = 1'b0; io.mode_i = MODE_ENC; io.tag_i = '0;
    io.tag_ready_i = 1'b0; io.exp_word_i = '0; io.exp_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_encrypt(input string name, input logic [127:0] t,
                              input int stall_at, input int stall_len, input bit mid_start);
    int sent = 0, stalls = 0, cyc = 0, done_cyc = -1;
    @(negedge clk);
    io.start_i = 1'b1; io.mode_i = MODE_ENC; io.tag_i = t;
    io.tag_ready_i = 1'b1; io.exp_valid_i = 1'b1; io.exp_word_i = 32'hDEAD_BEEF;
    for (int w = 0; w < 4; w++) sb_words.push_back(ref_word(t, w));
    sb_auth.push_back(1'b0);
    @(negedge clk);
    io.start_i = 1'b0;
    while (done_cyc < 0 && cyc < 40) begin
      cyc++;
      vectors++;
      if (io.tag_valid_o !== (sent < 4)) begin
        $display("FAIL %s_valid c%0d: tag_valid_o=%b, required %b", name, cyc, io.tag_valid_o, sent < 4);
        miscompares++;
      end
      if (io.exp_ready_o !== 1'b0) begin
        $display("FAIL %s_exp_ready c%0d: exp_ready_o=%b, required 0", name, cyc, io.exp_ready_o);
        miscompares++;
      end
      if (cyc == 1 && io.auth_ok_o !== 1'b0) begin
        $display("FAIL %s_auth_clear: auth_ok_o=%b, required 0", name, io.auth_ok_o);
        miscompares++;
      end
      if (io.done_o) begin
        done_cyc = cyc;
        vectors++;
        if (io.auth_ok_o !== sb_auth[0]) begin
          $display("FAIL %s_auth: auth_ok_o=%b, required %b", name, io.auth_ok_o, sb_auth[0]);
          miscompares++;
        end
        void'(sb_auth.pop_front());
      end
      if (io.tag_valid_o === 1'b1 && sb_words.size() > 0) begin
        vectors++;
        if (io.tag_word_o !== sb_words[0]) begin
          $display("FAIL %s_word%0d c%0d: tag_word_o=%h, required %h", name, sent, cyc,
                   io.tag_word_o, sb_words[0]);
          miscompares++;
        end
      end
      io.start_i = mid_start && (cyc == 2);
      io.mode_i  = (mid_start && cyc == 2) ? MODE_DEC : MODE_ENC;
      io.tag_i   = (mid_start && cyc == 2) ? ~t : t;
      io.tag_ready_i = !(sent == stall_at && stalls < stall_len);
      if (!io.tag_ready_i) stalls++;
      else if (io.tag_valid_o === 1'b1 && sent < 4) begin
        void'(sb_words.pop_front());
        sent++;
      end
      if (done_cyc < 0) @(negedge clk);
    end
    io.start_i = 1'b0; io.exp_valid_i = 1'b0;
    if (done_cyc < 0) begin
      recover(name);
    end else begin
      vectors++;
      if (done_cyc != 5 + stall_len || sent != 4 || sb_words.size() != 0) begin
        $display("FAIL %s_timing: done cycle %0d sent %0d left %0d, required %0d/4/0", name,
                 done_cyc, sent, sb_words.size(), 5 + stall_len);
        miscompares++;
        sb_words.delete();
      end
      @(negedge clk);
      vectors++;
      if (io.done_o !== 1'b0 || io.busy_o !== 1'b0 || io.tag_valid_o !== 1'b0) begin
        $display("FAIL %s_after: done=%b busy=%b valid=%b, required 0/0/0", name,
                 io.done_o, io.busy_o, io.tag_valid_o);
        miscompares++;
      end
    end
  endtask

  task automatic test_decrypt(input string name, input logic [127:0] t, input logic [127:0] e,
                              input logic [15:0] valid_pat, input int req_done);
    int got = 0, cyc = 0, done_cyc = -1, last_xfer = -1;
    @(negedge clk);
    io.start_i = 1'b1; io.mode_i = MODE_DEC; io.tag_i = t;
    io.tag_ready_i = 1'b1; io.exp_valid_i = 1'b0;
    sb_auth.push_back(t == e);
    @(negedge clk);
    io.start_i = 1'b0;
    while (done_cyc < 0 && cyc < 40) begin
      cyc++;
      vectors++;
      if (io.exp_ready_o !== (got < 4) || io.tag_valid_o !== 1'b0) begin
        $display("FAIL %s_ready c%0d: exp_ready_o=%b tag_valid_o=%b, required %b/0", name, cyc,
                 io.exp_ready_o, io.tag_valid_o, got < 4);
        miscompares++;
      end
      if (io.done_o) begin
        done_cyc = cyc;
        vectors++;
        if (io.auth_ok_o !== sb_auth[0]) begin
          $display("FAIL %s_auth: auth_ok_o=%b, required %b", name, io.auth_ok_o, sb_auth[0]);
          miscompares++;
        end
        void'(sb_auth.pop_front());
      end
      io.exp_valid_i = (got < 4) ? valid_pat[(cyc - 1) % 16] : 1'b1;
      io.exp_word_i  = (got < 4) ? ref_word(e, got) : 32'hFFFF_FFFF;
      if (io.exp_valid_i && got < 4) begin
        got++;
        if (got == 4) last_xfer = cyc;
      end
      if (done_cyc < 0) @(negedge clk);
    end
    io.exp_valid_i = 1'b0;
    if (done_cyc < 0) begin
      recover(name);
    end else begin
      vectors++;
      if (done_cyc != last_xfer + 1 || (req_done > 0 && done_cyc != req_done)) begin
        $display("FAIL %s_timing: done cycle %0d, required %0d (last transfer %0d)", name,
                 done_cyc, (req_done > 0) ? req_done : last_xfer + 1, last_xfer);
        miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (io.done_o !== 1'b0 || io.busy_o !== 1'b0) begin
        $display("FAIL %s_after: done=%b busy=%b, required 0/0", name, io.done_o, io.busy_o);
        miscompares++;
      end
    end
  endtask

  task automatic test_auth_hold(input logic req);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (io.auth_ok_o !== req || io.busy_o !== 1'b0) begin
        $display("FAIL auth_hold%0d: auth_ok_o=%b busy=%b, required %b/0", i, io.auth_ok_o,
                 io.busy_o, req);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_check();
    int seen_done = 0;
    @(negedge clk);
    io.start_i = 1'b1; io.mode_i = MODE_DEC; io.tag_i = T; io.exp_valid_i = 1'b0;
    @(negedge clk);
    io.start_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      io.exp_valid_i = 1'b1;
      io.exp_word_i  = ref_word(T, w);
      @(negedge clk);
    end
    io.exp_valid_i = 1'b0;
    vectors++;
    if (io.busy_o !== 1'b1 || io.exp_ready_o !== 1'b1) begin
      $display("FAIL reset_mid_pre: busy=%b exp_ready=%b, required 1/1", io.busy_o, io.exp_ready_o);
      miscompares++;
    end
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_mid_async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (io.done_o === 1'b1 || io.busy_o === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      $display("FAIL reset_mid_no_done: %0d busy/done cycles after abort, required 0", seen_done);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_encrypt("enc_plain", T, -1, 0, 1'b0);
    test_encrypt("enc_stall", T, 2, 3, 1'b0);
    test_decrypt("dec_gaps_ok", T, T, 16'b1010_0110_1101_0101, 0);
    test_auth_hold(1'b1);
    test_decrypt("dec_ok", T, T, 16'hFFFF, 5);
    test_decrypt("dec_last_bad", T, T_LAST, 16'hFFFF, 5);
    test_auth_hold(1'b0);
    test_decrypt("dec_first_bad", T, T_FIRST, 16'b0011_0011_0011_0011, 0);
    test_decrypt("dec_ok_again", T, T, 16'hFFFF, 5);
    test_encrypt("enc_mid_start", T, -1, 0, 1'b1);
    test_encrypt("enc_other", ~T, 0, 2, 1'b0);
    test_reset_mid_check();
    test_decrypt("dec_after_reset", T, T, 16'hFFFF, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
